// File: rtl/fpadd_seq.sv
// Operand sequencer for the multi-cycle fpadd unit: issues one start per accepted
// pair, masks the stale done level, and returns the sum or a quiet-NaN timeout result.
module fpadd_seq #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_timeout,
    output logic        fpa_start,
    output logic [31:0] fpa_a,
    output logic [31:0] fpa_b,
    input  logic [31:0] fpa_sum,
    input  logic        fpa_done,
    output logic        busy,
    output logic [15:0] op_count,
    output logic [7:0]  to_count
);

    localparam logic [31:0]   QNAN     = 32'h7FC0_0000;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   sum_q;
    logic          to_q;
    logic [15:0]   op_cnt_q;
    logic [7:0]    to_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            to_q     <= 1'b0;
            op_cnt_q <= '0;
            to_cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_SETTLE;
                end
                // done may still be high from the previous operation here
                S_SETTLE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (fpa_done) begin
                        sum_q    <= fpa_sum;
                        to_q     <= 1'b0;
                        op_cnt_q <= op_cnt_q + 16'd1;
                        state_q  <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        sum_q    <= QNAN;
                        to_q     <= 1'b1;
                        if (to_cnt_q != 8'hFF) begin
                            to_cnt_q <= to_cnt_q + 8'd1;
                        end
                        state_q  <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are pure state decodes; in_ready stays low while reset is held.
    assign in_ready    = reset && (state_q == S_IDLE);
    assign fpa_start   = (state_q == S_ISSUE);
    assign out_valid   = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign fpa_a       = a_q;
    assign fpa_b       = b_q;
    assign out_sum     = sum_q;
    assign out_timeout = to_q;
    assign op_count    = op_cnt_q;
    assign to_count    = to_cnt_q;

endmodule

// File: tb/tb_fpadd_seq.sv
// Directed bench for fpadd_seq: table of single operations against a behavioural
// adder model, plus backpressure, reset-in-WAIT and timeout-saturation sequences.
module tb_fpadd_seq;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_timeout;
    logic        fpa_start;
    logic [31:0] fpa_a;
    logic [31:0] fpa_b;
    logic [31:0] fpa_sum = '0;
    logic        fpa_done = 1'b0;
    logic        busy;
    logic [15:0] op_count;
    logic [7:0]  to_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_op = 0;
    int exp_to = 0;

    fpadd_seq #(.TIMEOUT(TO), .CW(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_timeout(out_timeout),
        .fpa_start(fpa_start), .fpa_a(fpa_a), .fpa_b(fpa_b),
        .fpa_sum(fpa_sum), .fpa_done(fpa_done),
        .busy(busy), .op_count(op_count), .to_count(to_count)
    );

    always #5 clk = ~clk;

    // Adder model: done rises so that it is first sampled k edges after the start edge
    // (k=0: never). With mdl_stale the old done level lingers one extra cycle.
    int          mdl_k = 0;
    logic [31:0] mdl_sum = '0;
    bit          mdl_stale = 1'b0;
    int          done_cnt = 0;
    bit          pending = 1'b0;
    bit          drop_pending = 1'b0;

    always @(posedge clk) begin
        if (fpa_start) begin
            done_cnt <= (mdl_k == 0) ? 0 : mdl_k - 1;
            pending  <= (mdl_k != 0);
            if (mdl_stale) drop_pending <= 1'b1;
            else           fpa_done <= 1'b0;
        end else begin
            if (drop_pending) begin
                fpa_done     <= 1'b0;
                drop_pending <= 1'b0;
            end
            if (pending) begin
                if (done_cnt <= 1) begin
                    fpa_done <= 1'b1;
                    fpa_sum  <= mdl_sum;
                    pending  <= 1'b0;
                end else begin
                    done_cnt <= done_cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Caller is at a negedge in IDLE; returns at the negedge inside cycle E+1.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input int k,
                            input logic [31:0] s, input bit stale);
        mdl_k = k; mdl_sum = s; mdl_stale = stale;
        in_a = a; in_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output int starts);
        lat = 1; starts = 0;
        while (!out_valid && lat < 40) begin
            if (fpa_start) starts++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          k;
        logic [31:0] sum;
        bit          stale;
        logic [31:0] exp_sum;
        bit          exp_to;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int starts;
        logic [31:0] held;
        bit seen;

        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 3,  32'h4040_0000, 1'b0, 32'h4040_0000, 1'b0, 5};
        vecs[1] = '{32'h40A0_0000, 32'h40A0_0000, 4,  32'h4120_0000, 1'b1, 32'h4120_0000, 1'b0, 6};
        vecs[2] = '{32'h4040_0000, 32'h4080_0000, 2,  32'h40E0_0000, 1'b0, 32'h40E0_0000, 1'b0, 4};
        vecs[3] = '{32'hBF80_0000, 32'h3F80_0000, 5,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 7};
        vecs[4] = '{32'h7F80_0000, 32'hFF80_0000, 0,  32'h1234_5678, 1'b0, 32'h7FC0_0000, 1'b1, 11};
        vecs[5] = '{32'h4100_0000, 32'h4100_0000, 9,  32'h4180_0000, 1'b0, 32'h4180_0000, 1'b0, 11};
        vecs[6] = '{32'h4110_0000, 32'h3F80_0000, 10, 32'h4120_0000, 1'b0, 32'h7FC0_0000, 1'b1, 11};

        // Reset state
        #12;
        chk("rst_ctrl", {28'd0, fpa_start, out_valid, out_timeout, busy}, 32'd0);
        chk("rst_data", fpa_a | fpa_b | out_sum, 32'd0);
        chk("rst_cnt", {8'd0, op_count, to_count}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_busy", {31'd0, busy}, 32'd0);

        // Table of single operations
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].stale) chk($sformatf("v%0d_stale_pre", i), {31'd0, fpa_done}, 32'd1);
            start_op(vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].sum, vecs[i].stale);
            wait_out(lat, starts);
            if (vecs[i].exp_to) exp_to++; else exp_op++;
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_starts", i), starts, 1);
            chk($sformatf("v%0d_sum", i), out_sum, vecs[i].exp_sum);
            chk($sformatf("v%0d_to", i), {31'd0, out_timeout}, {31'd0, vecs[i].exp_to});
            chk($sformatf("v%0d_fpa_a", i), fpa_a, vecs[i].a);
            chk($sformatf("v%0d_fpa_b", i), fpa_b, vecs[i].b);
            chk($sformatf("v%0d_op_count", i), op_count, exp_op);
            chk($sformatf("v%0d_to_count", i), to_count, exp_to);
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            drain();
        end

        // Backpressure in RESP with a new pair already offered
        start_op(32'h3F80_0000, 32'h3F80_0000, 3, 32'h4000_0000, 1'b0);
        wait_out(lat, starts);
        exp_op++;
        held = out_sum;
        chk("bp_sum_first", held, 32'h4000_0000);
        in_a = 32'h4040_0000; in_b = 32'h4040_0000; in_valid = 1'b1;
        mdl_k = 3; mdl_sum = 32'h40C0_0000; mdl_stale = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_sum", c), out_sum, held);
            chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_fpa_a", c), fpa_a, 32'h3F80_0000);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_start", {31'd0, fpa_start}, 32'd1);
        chk("bp_next_fpa_a", fpa_a, 32'h4040_0000);
        wait_out(lat, starts);
        exp_op++;
        chk("bp_next_lat", lat, 5);
        chk("bp_next_sum", out_sum, 32'h40C0_0000);
        chk("bp_op_count", op_count, exp_op);
        drain();

        // Reset during WAIT; the model's late done must not produce a result
        start_op(32'h4000_0000, 32'h4000_0000, 6, 32'h4080_0000, 1'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_ctrl", {28'd0, fpa_start, out_valid, out_timeout, busy}, 32'd0);
        chk("mid_rst_data", fpa_a | fpa_b | out_sum, 32'd0);
        chk("mid_rst_cnt", {8'd0, op_count, to_count}, 32'd0);
        exp_op = 0; exp_to = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rel_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            seen = seen | out_valid | fpa_start;
        end
        chk("mid_no_pulse", {31'd0, seen}, 32'd0);

        // Timeout counter saturation
        for (int n = 0; n < 256; n++) begin
            start_op(n, ~n, 0, 32'h0, 1'b0);
            wait_out(lat, starts);
            if (exp_to < 255) exp_to++;
            drain();
        end
        chk("sat_to_count", to_count, exp_to);
        chk("sat_to_255", to_count, 32'd255);
        chk("sat_op_count", op_count, exp_op);
        chk("sat_last_to", {31'd0, out_timeout}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpadd_seq.md
# fpadd_seq

Operand sequencer and initiator for the multi-cycle floating-point adder (`fpadd`). It accepts IEEE-754 single-precision operand pairs on a valid/ready stream. For each pair it drives the adder's `start`/`a`/`b` handshake and waits for `done`, ignoring the stale `done` left over from the previous operation. It returns the sum, or a timeout result, on a valid/ready output stream. It sits between the datapath operand queue and the adder instance and keeps completion and timeout statistics.

## Interface
Parameters:
- `TIMEOUT`, default 64: number of WAIT cycles allowed before the operation is abandoned. Legal range 2..255.
- `CW`, default 8: width of the WAIT cycle counter. Must satisfy 2^CW > TIMEOUT.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair available.
- `in_ready`  out  1  sequencer can accept a pair.
- `in_a`, `in_b`  in  32  operands in IEEE-754 single-precision format.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  32  result word.
- `out_timeout`  out  1  set when the result is the timeout substitute rather than an adder sum.
- `fpa_start`  out  1  start pulse to the adder.
- `fpa_a`, `fpa_b`  out  32  operands presented to the adder.
- `fpa_sum`  in  32  adder result.
- `fpa_done`  in  1  adder completion flag. It is level-type and stays high until the next start.
- `busy`  out  1  high in every state except IDLE.
- `op_count`  out  16  number of completed (non-timeout) operations; wraps at 2^16.
- `to_count`  out  8  number of timeouts; saturates at 255.

## Operation
- States: IDLE, ISSUE, SETTLE, WAIT, RESP.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch `in_a`→`fpa_a` and `in_b`→`fpa_b`, then go to ISSUE.
- ISSUE:
  - `fpa_start`=1 for exactly one cycle.
  - Clear the wait counter.
  - Go to SETTLE.
- SETTLE:
  - Lasts one cycle.
  - `fpa_done` is ignored because it may still be high from the previous operation.
  - Go to WAIT.
- WAIT:
  - If `fpa_done`=1: latch `fpa_sum`→`out_sum`, set `out_timeout`=0, increment `op_count`, go to RESP.
  - Else if counter==TIMEOUT-1: set `out_sum`=32'h7FC00000 (quiet NaN), `out_timeout`=1, increment `to_count` (saturating), go to RESP.
  - Otherwise increment the counter.
  - If `fpa_done` is seen on the same cycle the counter reaches TIMEOUT-1, the done takes priority.
- RESP:
  - `out_valid`=1. `out_sum` and `out_timeout` are held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready`=0 in this state, so a pair offered during RESP is accepted no earlier than the cycle after returning to IDLE.
- `fpa_a` and `fpa_b` hold their values from the IDLE accept until the next accept. They must not change while the adder is working.
- The sequencer performs no arithmetic on the operands or the result. `out_sum` is a pass-through of `fpa_sum`.

## Timing
- Reset asserted (`reset`=0):
  - State goes to IDLE immediately (asynchronous).
  - All outputs go to 0: `fpa_start`, `fpa_a`, `fpa_b`, `out_valid`, `out_sum`, `out_timeout`, `op_count`, `to_count`, `busy`.
  - The exception is `in_ready`, which is 1 as soon as reset is released.
- Reset mid-operation: any in-flight pair and any pending result are discarded. No output pulse is produced after release.
- Output timing:
  - All outputs are registered or decoded from state alone.
  - No combinational path from `in_valid`, `out_ready` or `fpa_done` to any output.
- Latency, measured from the accept edge E:
  - `fpa_start` is high during cycle E+1 only.
  - `fpa_done` is first sampled at the end of cycle E+3.
  - If the adder raises `done` k cycles after the start edge (k≥2), `out_valid` rises k+2 cycles after E. The minimum is 4.
  - A timeout gives `out_valid` TIMEOUT+3 cycles after E.
- Throughput: at most one operation per (latency + 1) cycles, because of the IDLE turnaround cycle.
- The counter is CW bits wide and never wraps, since it stops at TIMEOUT-1.

## Test plan
- Accept `in_a`=32'h3F800000, `in_b`=32'h40000000. The adder model raises `done` 3 cycles after start with `fpa_sum`=32'h40400000. Expect:
  - a single `fpa_start` pulse;
  - `out_valid` with `out_sum`=32'h40400000 and `out_timeout`=0;
  - `op_count`=1.
- Hold `fpa_done` high from the previous operation through ISSUE/SETTLE, then drop it; the model raises it again 4 cycles later with a new sum. Expect the stale done to be ignored, with `out_sum` equal to the new sum.
- Adder model never raises `done`, TIMEOUT=8. Expect:
  - `out_valid` exactly 11 cycles after accept;
  - `out_sum`=32'h7FC00000, `out_timeout`=1;
  - `to_count`=1, `op_count` unchanged.
- `out_ready` held low for 5 cycles in RESP while `in_valid`=1. Expect:
  - `out_sum` stable throughout and `in_ready`=0;
  - after `out_ready`=1, the next pair is accepted one cycle later.
- Assert `reset`=0 during WAIT. Expect all outputs to 0 immediately and `in_ready`=1 after release. A late `fpa_done` produces no `out_valid`.
- Run 256 forced timeouts. Expect `to_count` to saturate at 255.
